// File: rtl/v_result_router.sv
// Result router: buffers tile result vectors in a small FIFO and forwards each
// to one or all neighbour channels using the write_rdy/write_en/write_ack handshake.
module v_result_router #(
    parameter int unsigned width      = 16,
    parameter int unsigned num_inputs = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [width*num_inputs-1:0] in_data,
    input  logic [3:0]                  in_dest,
    output logic                        full,
    output logic                        overflow,
    output logic [$clog2(DEPTH):0]      count,
    input  logic [NUM_CH-1:0]           out_rdy,
    output logic [NUM_CH-1:0]           out_en,
    output logic [width*num_inputs-1:0] out_data,
    input  logic [NUM_CH-1:0]           out_ack
);

    localparam int unsigned DataW = width * num_inputs;
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic              overflow_q, overflow_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [DataW-1:0]  data_q, data_d;

    logic [DataW-1:0]  data_mem [DEPTH];
    logic [NUM_CH-1:0] mask_mem [DEPTH];

    logic              full_w;
    logic              push;
    logic              pop;
    logic [NUM_CH-1:0] push_mask;
    logic [DataW-1:0]  head_data;
    logic [NUM_CH-1:0] head_mask;

    assign full_w    = (count_q == CntW'(DEPTH));
    assign push      = in_valid && !full_w;
    // in_dest[2] carries no routing meaning and is deliberately ignored.
    assign push_mask = in_dest[3] ? {NUM_CH{1'b1}}
                                  : ({{(NUM_CH-1){1'b0}}, 1'b1} << in_dest[1:0]);
    assign head_data = data_mem[rptr_q];
    assign head_mask = mask_mem[rptr_q];

    assign full     = full_w;
    assign overflow = overflow_q;
    assign count    = count_q;
    assign out_en   = en_q;
    assign out_data = data_q;

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= in_data;
            mask_mem[wptr_q] <= push_mask;
        end
    end

    always_comb begin
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        count_d    = count_q + CntW'(push) - CntW'(pop);
        // A drop is flagged even when a pop frees a slot in the same cycle.
        overflow_d = overflow_q | (in_valid & full_w);
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        done_d  = done_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    data_d = head_data;
                    en_d   = head_mask & out_rdy;
                    if (|(head_mask & out_rdy)) begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (done_q == head_mask) begin
                    pop     = 1'b1;
                    done_d  = '0;
                    state_d = StIdle;
                end else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (en_q[c]) begin
                            // Once raised, write_en is held until acked, whatever rdy does.
                            if (out_ack[c]) begin
                                en_d[c]   = 1'b0;
                                done_d[c] = 1'b1;
                            end
                        end else if (head_mask[c] && !done_q[c] && out_rdy[c]) begin
                            en_d[c] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            en_q       <= '0;
            done_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            en_q       <= en_d;
            done_q     <= done_d;
            data_q     <= data_d;
        end
    end

endmodule
